// File: rtl/sram_pkg.sv
// Shared types and constants for the VGA/CPU async SRAM arbiter.
// Holds the state encoding, default bus widths and the SRAM control-pin patterns.
package sram_pkg;

  localparam int unsigned SRAM_ADDR_W = 18;
  localparam int unsigned SRAM_DATA_W = 16;
  localparam int unsigned CNT_W       = 3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_VGA_RD   = 3'd1,
    ST_VGA_HOLD = 3'd2,
    ST_CPU_RD   = 3'd3,
    ST_CPU_WR   = 3'd4,
    ST_CPU_WREC = 3'd5
  } state_t;

  typedef struct packed {
    logic ce_n;
    logic oe_n;
    logic we_n;
    logic dq_oe;
  } pin_ctl_t;

  // dq_oe is only ever set in patterns where oe_n is high, so the bus never fights the SRAM
  localparam pin_ctl_t PINS_IDLE  = '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1, dq_oe: 1'b0};
  localparam pin_ctl_t PINS_READ  = '{ce_n: 1'b0, oe_n: 1'b0, we_n: 1'b1, dq_oe: 1'b0};
  localparam pin_ctl_t PINS_WRITE = '{ce_n: 1'b0, oe_n: 1'b1, we_n: 1'b0, dq_oe: 1'b1};
  localparam pin_ctl_t PINS_WREC  = '{ce_n: 1'b0, oe_n: 1'b1, we_n: 1'b1, dq_oe: 1'b1};

  function automatic logic [CNT_W-1:0] lastCount(input int unsigned waitCycles);
    return CNT_W'(waitCycles - 1);
  endfunction

endpackage

// File: rtl/sram_arbiter_vga.sv
// Single-port async SRAM arbiter: VGA word fetches at strict priority, CPU reads/writes otherwise.
// Every output, including all SRAM pins, comes straight from a register.
module sram_arbiter_vga
  import sram_pkg::*;
#(
  parameter int unsigned ADDR_W  = SRAM_ADDR_W,
  parameter int unsigned DATA_W  = SRAM_DATA_W,
  parameter int unsigned RD_WAIT = 2,
  parameter int unsigned WR_WAIT = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_data_rq_vga,
  input  logic [ADDR_W-1:0] i_sram_adr_vga,
  output logic              o_grant_vga,
  output logic [DATA_W-1:0] o_vga_data,
  input  logic              i_cpu_rq,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_adr,
  input  logic [DATA_W-1:0] i_cpu_din,
  output logic [DATA_W-1:0] o_cpu_dout,
  output logic              o_cpu_ack,
  output logic [ADDR_W-1:0] o_sram_adr,
  input  logic [DATA_W-1:0] i_sram_dq_i,
  output logic [DATA_W-1:0] o_sram_dq_o,
  output logic              o_sram_dq_oe,
  output logic              o_sram_ce_n,
  output logic              o_sram_oe_n,
  output logic              o_sram_we_n
);

  localparam logic [CNT_W-1:0] RD_LAST   = lastCount(RD_WAIT);
  localparam logic [CNT_W-1:0] WR_LAST   = lastCount(WR_WAIT);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(1);

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  pin_ctl_t          r_pins;
  logic [ADDR_W-1:0] r_adr;
  logic [DATA_W-1:0] r_dq_o;
  logic [DATA_W-1:0] r_vga_data;
  logic [DATA_W-1:0] r_cpu_dout;
  logic              r_grant;
  logic              r_ack;
  logic              r_ack_d;

  state_t            w_state;
  logic [CNT_W-1:0]  w_cnt;
  pin_ctl_t          w_pins;
  logic [ADDR_W-1:0] w_adr;
  logic [DATA_W-1:0] w_dq_o;
  logic [DATA_W-1:0] w_vga_data;
  logic [DATA_W-1:0] w_cpu_dout;
  logic              w_grant;
  logic              w_ack;
  logic              w_cpu_req;

  // The CPU keeps cpu_rq high while it reacts to its ack; that stale level must not restart it.
  assign w_cpu_req = i_cpu_rq & ~r_ack & ~r_ack_d;

  always_comb begin
    w_state    = r_state;
    w_cnt      = r_cnt;
    w_pins     = r_pins;
    w_adr      = r_adr;
    w_dq_o     = r_dq_o;
    w_vga_data = r_vga_data;
    w_cpu_dout = r_cpu_dout;
    w_grant    = 1'b0;
    w_ack      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_cnt  = '0;
        w_pins = PINS_IDLE;
        if (i_data_rq_vga) begin
          w_adr   = i_sram_adr_vga;
          w_pins  = PINS_READ;
          w_state = ST_VGA_RD;
        end else if (w_cpu_req) begin
          w_adr = i_cpu_adr;
          if (i_cpu_we) begin
            w_dq_o  = i_cpu_din;
            w_pins  = PINS_WRITE;
            w_state = ST_CPU_WR;
          end else begin
            w_pins  = PINS_READ;
            w_state = ST_CPU_RD;
          end
        end
      end

      ST_VGA_RD: begin
        if (r_cnt == RD_LAST) begin
          w_vga_data = i_sram_dq_i;
          w_grant    = 1'b1;
          w_pins     = PINS_IDLE;
          w_cnt      = '0;
          w_state    = ST_VGA_HOLD;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end

      // The VGA feeder lowers its request two cycles after the grant, so it is ignored here.
      ST_VGA_HOLD: begin
        if (r_cnt == HOLD_LAST) begin
          w_cnt   = '0;
          w_state = ST_IDLE;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end

      ST_CPU_RD: begin
        if (r_cnt == RD_LAST) begin
          w_cpu_dout = i_sram_dq_i;
          w_ack      = 1'b1;
          w_pins     = PINS_IDLE;
          w_cnt      = '0;
          w_state    = ST_IDLE;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end

      ST_CPU_WR: begin
        if (r_cnt == WR_LAST) begin
          w_pins  = PINS_WREC;
          w_ack   = 1'b1;
          w_cnt   = '0;
          w_state = ST_CPU_WREC;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end

      ST_CPU_WREC: begin
        w_pins  = PINS_IDLE;
        w_cnt   = '0;
        w_state = ST_IDLE;
      end

      default: begin
        w_pins  = PINS_IDLE;
        w_cnt   = '0;
        w_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_pins     <= PINS_IDLE;
      r_adr      <= '0;
      r_dq_o     <= '0;
      r_vga_data <= '0;
      r_cpu_dout <= '0;
      r_grant    <= 1'b0;
      r_ack      <= 1'b0;
      r_ack_d    <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_cnt      <= w_cnt;
      r_pins     <= w_pins;
      r_adr      <= w_adr;
      r_dq_o     <= w_dq_o;
      r_vga_data <= w_vga_data;
      r_cpu_dout <= w_cpu_dout;
      r_grant    <= w_grant;
      r_ack      <= w_ack;
      r_ack_d    <= r_ack;
    end
  end

  assign o_grant_vga  = r_grant;
  assign o_vga_data   = r_vga_data;
  assign o_cpu_dout   = r_cpu_dout;
  assign o_cpu_ack    = r_ack;
  assign o_sram_adr   = r_adr;
  assign o_sram_dq_o  = r_dq_o;
  assign o_sram_dq_oe = r_pins.dq_oe;
  assign o_sram_ce_n  = r_pins.ce_n;
  assign o_sram_oe_n  = r_pins.oe_n;
  assign o_sram_we_n  = r_pins.we_n;

endmodule
